// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and dither LFSR helper for the PWM audio output stage
package audio_pkg;

    typedef logic [7:0] lfsr_t;

    localparam int    SAMPLE_W_DEFAULT = 8;
    localparam lfsr_t MIDSCALE         = 8'h80;
    localparam lfsr_t LFSR_SEED        = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3 of a left-shifting register
    localparam lfsr_t LFSR_TAPS        = 8'hB8;

    function automatic lfsr_t lfsr_next(input lfsr_t s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - PWM prescaler and period counter with period-boundary strobe
module pwm_tick_gen #(
    parameter int SAMPLE_W = 8,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic [SAMPLE_W-1:0] pwm_cnt,
    output logic                boundary
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick     = enable && (pre_cnt == PRE_LAST);
    assign boundary = tick && (&pwm_cnt);

    // Disabled counters sit at zero so a re-enable always starts a fresh period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (!enable) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - one-sample buffered PWM audio output with sticky underrun flag
// Optional duty dither enabled by defining PWM_AUDIO_DITHER_EN.
module pwm_audio_out
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sound_in,
    input  logic                sound_valid,
    output logic                sound_ready,
    input  logic                enable,
    input  logic                underrun_clr,
    output logic                pwm_out,
    output logic                sample_tick,
    output logic                underrun
);

    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [SAMPLE_W-1:0] pwm_cnt;
    logic                boundary;
    logic [SAMPLE_W-1:0] sample_buf;
    logic [SAMPLE_W-1:0] duty;
    logic [SAMPLE_W-1:0] load_duty;
    logic                buf_full;
    logic                accept;

    pwm_tick_gen #(
        .SAMPLE_W (SAMPLE_W),
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .pwm_cnt  (pwm_cnt),
        .boundary (boundary)
    );

    assign sound_ready = !buf_full;
    assign accept      = sound_valid && !buf_full;

`ifdef PWM_AUDIO_DITHER_EN
    lfsr_t             lfsr;
    logic [SAMPLE_W:0] dither_sum;

    // Flipping the sign bit turns two's complement into offset binary; dither saturates at full scale
    assign dither_sum = {1'b0, sample_buf ^ MID} + {{SAMPLE_W{1'b0}}, lfsr[0]};
    assign load_duty  = dither_sum[SAMPLE_W] ? '1 : dither_sum[SAMPLE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (boundary) begin
            lfsr <= lfsr_next(lfsr);
        end
    end
`else
    assign load_duty = sample_buf ^ MID;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_buf  <= '0;
            buf_full    <= 1'b0;
            duty        <= MID;
            pwm_out     <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= boundary;
            pwm_out     <= enable && (pwm_cnt < duty);

            // accept needs an empty buffer, so it never collides with a boundary drain
            if (accept) begin
                sample_buf <= sound_in;
                buf_full   <= 1'b1;
            end else if (boundary && buf_full) begin
                buf_full <= 1'b0;
            end

            if (!enable) begin
                duty <= MID;
            end else if (boundary && buf_full) begin
                duty <= load_duty;
            end

            if (boundary && !buf_full) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule
